// File: rtl/dram_slave_pkg.sv
// rtl/dram_slave_pkg.sv - shared types, widths and helpers for the dram_slave responder
//
// Purpose: FSM state encoding, bus widths, LFSR constants and the depth-to-index-width helper
//          used by dram_slave and dram_slave_mem.
// Ports:   none (package).

package dram_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Wide enough for LATENCY-1 (max 14) plus up to 3 jitter cycles.
    localparam int CNT_W  = 5;

    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: the feedback bit is the
    // XOR of state bits 0, 2, 3 and 5, and it enters at bit 15.
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Number of word-index bits for a power-of-two DEPTH.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dram_slave_mem.sv
// rtl/dram_slave_mem.sv - single-port word array with byte-enabled write and registered read
//
// Purpose: storage for dram_slave. Synchronous read into an output register that holds its
//          value while i_rd_en is low; synchronous byte-enabled write. No reset on any state.
// Ports:
//   clock      in   system clock
//   i_addr     in   word index
//   i_rd_en    in   load o_rd_data from the array at the next edge
//   i_wr_en    in   write enabled bytes of i_wr_data at the next edge
//   i_be       in   per-byte write enables
//   i_wr_data  in   write data
//   o_rd_data  out  registered read data

module dram_slave_mem
    import dram_slave_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic              clock,
    input  logic [AW-1:0]     i_addr,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [BE_W-1:0]   i_be,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dram_slave.sv
// rtl/dram_slave.sv - Avalon-MM-style single-word memory responder with fixed wait latency
//
// Purpose: accepts one read or write at a time, holds o_wait_request high for LATENCY cycles,
//          then completes the access in a single ack cycle. Optional build macro
//          DRAM_SLAVE_LFSR_JITTER_EN adds 0..3 pseudo-random extra wait cycles per access.
// Ports:
//   clock            in   system clock
//   reset            in   synchronous active-high reset
//   i_read           in   read request, held until the ack cycle
//   i_write          in   write request, held until the ack cycle
//   i_address        in   byte address; [1:0] and bits above the array are ignored
//   i_byte_enable    in   per-byte write enables
//   i_write_data     in   write data
//   o_read_data      out  read data, valid in the ack cycle, held afterwards
//   o_wait_request   out  low for exactly the ack cycle

module dram_slave
    import dram_slave_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [31:0]       i_address,
    input  logic [BE_W-1:0]   i_byte_enable,
    input  logic [DATA_W-1:0] i_write_data,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_wait_request
);

    localparam int AW = clog2_depth(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [AW-1:0]     r_index;
    logic              r_op_write;
    logic [BE_W-1:0]   r_be;
    logic [DATA_W-1:0] r_wdata;
    logic              r_rd_valid;

    logic [AW-1:0]     w_addr_index;
    logic [AW-1:0]     w_mem_addr;
    logic              w_accept;
    logic              w_req_held;
    logic              w_mem_rd_en;
    logic              w_mem_wr_en;
    logic [CNT_W-1:0]  w_lat_m1;
    logic [DATA_W-1:0] w_mem_q;
    logic              w_unused_addr;

    // Upper bits alias the array; the low two select a byte within the word.
    assign w_addr_index  = i_address[AW+1:2];
    assign w_unused_addr = ^{i_address[31:AW+2], i_address[1:0]};

    assign w_accept   = (r_state == IDLE) && (i_read || i_write);
    // Only the request that was accepted keeps the access alive.
    assign w_req_held = r_op_write ? i_write : i_read;

`ifdef DRAM_SLAVE_LFSR_JITTER_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);
    // Jitter uses the LFSR value present when the request is accepted.
    assign w_lat_m1  = LAT_M1 + {3'b000, r_lfsr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end
`else
    assign w_lat_m1 = LAT_M1;
`endif

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_mem_rd_en  = 1'b0;
        w_mem_wr_en  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_count_next = w_lat_m1;
                    if (w_lat_m1 == '0) begin
                        w_state_next = ACK;
                        w_mem_rd_en  = i_read;
                    end else begin
                        w_state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!w_req_held) begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count - 1'b1;
                    if (r_count == CNT_W'(1)) begin
                        w_state_next = ACK;
                        w_mem_rd_en  = !r_op_write;
                    end
                end
            end
            ACK: begin
                // The write commits on the edge leaving ACK; never chain a new request here.
                w_state_next = IDLE;
                w_mem_wr_en  = r_op_write;
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_op_write <= 1'b0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            if (w_accept) begin
                r_index    <= w_addr_index;
                r_op_write <= !i_read;
                r_be       <= i_byte_enable;
                r_wdata    <= i_write_data;
            end
            if (w_mem_rd_en) begin
                r_rd_valid <= 1'b1;
            end
        end
    end

    // In IDLE a LATENCY==1 read must address the array before the index is latched.
    assign w_mem_addr = (r_state == IDLE) ? w_addr_index : r_index;

    dram_slave_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock     (clock),
        .i_addr    (w_mem_addr),
        .i_rd_en   (w_mem_rd_en && !reset),
        .i_wr_en   (w_mem_wr_en && !reset),
        .i_be      (r_be),
        .i_wr_data (r_wdata),
        .o_rd_data (w_mem_q)
    );

    // The array's read register has no reset, so mask it until a read has landed.
    assign o_read_data    = r_rd_valid ? w_mem_q : '0;
    assign o_wait_request = (r_state != ACK);

endmodule

// File: tb/tb_dram_slave.sv
// tb/tb_dram_slave.sv - self-checking bench for dram_slave (DEPTH=1024, LATENCY=4)

module tb_dram_slave;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        i_read;
    logic        i_write;
    logic [31:0] i_address;
    logic [3:0]  i_byte_enable;
    logic [31:0] i_write_data;
    logic [31:0] o_read_data;
    logic        o_wait_request;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_q [$];
    logic [15:0] lfsr_ref;

    dram_slave #(
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .i_read         (i_read),
        .i_write        (i_write),
        .i_address      (i_address),
        .i_byte_enable  (i_byte_enable),
        .i_write_data   (i_write_data),
        .o_read_data    (o_read_data),
        .o_wait_request (o_wait_request)
    );

    always #5 clock = ~clock;

    // Reference for x^16+x^14+x^13+x^11+1, Fibonacci, shifting toward bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[15-15] ^ s[15-13] ^ s[15-12] ^ s[15-10];
        return {fb, s[15:1]};
    endfunction

    function automatic int next_latency();
        int l;
        l = LAT;
`ifdef DRAM_SLAVE_LFSR_JITTER_EN
        l = LAT + int'(lfsr_ref[1:0]);
        lfsr_ref = lfsr_step(lfsr_ref);
`endif
        return l;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_drive();
        i_read        = 1'b0;
        i_write       = 1'b0;
        i_address     = '0;
        i_byte_enable = '0;
        i_write_data  = '0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        idle_drive();
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b0;
        lfsr_ref = 16'hACE1;
    endtask

    // Starts and ends 1 time unit after a rising edge. Cycle 0 is the first request cycle.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd, input string tag);
        int          lat;
        int          idx;
        int          cyc;
        bit          seen;
        logic [31:0] exp_rd;
        lat  = next_latency();
        idx  = int'((addr >> 2) % DEPTH);
        seen = 1'b0;
        cyc  = 0;
        i_read = rd; i_write = wr; i_address = addr; i_byte_enable = be; i_write_data = wd;
        if (rd) exp_q.push_back(model[idx]);
        for (int c = 0; c < 64; c++) begin
            @(negedge clock);
            if (!o_wait_request) begin
                seen = 1'b1;
                cyc  = c;
                break;
            end
            @(posedge clock); #1;
        end
        check32({tag, "_ack_seen"}, 32'(seen), 32'd1);
        check32({tag, "_ack_cycle"}, 32'(cyc), 32'(lat));
        if (rd) begin
            exp_rd = exp_q.pop_front();
            if (seen) check32({tag, "_rdata"}, o_read_data, exp_rd);
        end else if (wr && seen) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge clock); #1;
        exp_rd = o_read_data;
        idle_drive();
        @(negedge clock);
        check32({tag, "_wait_after_ack"}, 32'(o_wait_request), 32'd1);
        check32({tag, "_rdata_hold"}, o_read_data, exp_rd);
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        idle_drive();
        lfsr_ref = 16'hACE1;
        do_reset();

        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check32("reset_wait", 32'(o_wait_request), 32'd1);
            check32("reset_rdata", o_read_data, 32'h0);
        end
        @(posedge clock); #1;

        access(1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, "wr_full");
        access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "rd_full");
        access(1'b0, 1'b1, 32'h10, 4'b0101, 32'h11223344, "wr_partial");
        check32("partial_model", model[4], 32'hDE22BE44);
        access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "rd_partial");

        access(1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'hA5A5A5A5, "wr_wrap");
        access(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, "rd_wrap");
        access(1'b1, 1'b0, 32'h13, 4'h0, 32'h0, "rd_low_bits");

        access(1'b0, 1'b1, 32'h20, 4'hF, 32'hCAFEF00D, "wr_20");
        access(1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678, "rd_wr_both");
        access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "rd_after_both");

        // Write dropped during BUSY: no ack, array untouched.
        begin
            void'(next_latency());
            i_write = 1'b1; i_address = 32'h20; i_byte_enable = 4'hF; i_write_data = 32'hFFFFFFFF;
            for (int c = 0; c < 2; c++) begin
                @(negedge clock);
                check32("drop_wait_pre", 32'(o_wait_request), 32'd1);
                @(posedge clock); #1;
            end
            idle_drive();
            for (int c = 0; c < 8; c++) begin
                @(negedge clock);
                check32("drop_no_ack", 32'(o_wait_request), 32'd1);
                @(posedge clock); #1;
            end
        end
        access(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, "rd_after_drop");

        // Reset during BUSY of a write: discarded, older words retained.
        access(1'b0, 1'b1, 32'h30, 4'hF, 32'h0BADC0DE, "wr_30");
        begin
            void'(next_latency());
            i_write = 1'b1; i_address = 32'h30; i_byte_enable = 4'hF; i_write_data = 32'h55555555;
            for (int c = 0; c < 2; c++) begin
                @(negedge clock);
                check32("rst_wait_pre", 32'(o_wait_request), 32'd1);
                @(posedge clock); #1;
            end
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            idle_drive();
            lfsr_ref = 16'hACE1;
            @(negedge clock);
            check32("rst_mid_wait", 32'(o_wait_request), 32'd1);
            check32("rst_mid_rdata", o_read_data, 32'h0);
            @(posedge clock); #1;
        end
        access(1'b1, 1'b0, 32'h30, 4'h0, 32'h0, "rd_after_rst");
        access(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, "rd_retained");

        // Eight consecutive reads from a fresh LFSR seed.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            access(1'b1, 1'b0, 32'h10 + 32'(k % 2) * 32'h10, 4'h0, 32'h0, "rd_seq");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_slave.md
Name: dram_slave

Overview:
- Avalon-MM-style memory responder: the far end of the single-word master interface used by the accelerator DRAM master.
- Accepts one Read or Write at a time, holds WaitRequest high for a fixed latency, then completes the access in a single ack cycle.
- Used as the behavioural DRAM model in accelerator benches and as an on-chip scratch memory on FPGA builds.

Parameters:
- DEPTH, 1024, number of 32-bit words; must be a power of two.
- LATENCY, 4, cycles from first sampled request to the WaitRequest-low cycle; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset.
- Read  in  1  read request; held by master until the ack cycle.
- Write  in  1  write request; held by master until the ack cycle.
- Address  in  32  byte address; bits [1:0] ignored.
- ByteEnable  in  4  per-byte write enables; ignored for reads.
- WriteData  in  32  write data.
- ReadData  out  32  read data; valid only in the ack cycle.
- WaitRequest  out  1  high = not done; low for exactly one cycle per completed access.

Interface: reset reset, synchronous, active-high; clock clock.

Behaviour:
- Reset values: state IDLE, ReadData=0, WaitRequest=1, latency counter=0. Memory array is not cleared by reset.
- Word index = Address[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias (wrap) modulo DEPTH*4.
- FSM states: IDLE, BUSY, ACK. WaitRequest is combinational: 0 only in ACK, 1 otherwise.
- IDLE:
  - Read or Write sampled high at edge n: latch word index, operation, ByteEnable and WriteData.
  - Load counter with LATENCY-1.
  - Go to ACK if LATENCY==1, else to BUSY.
- BUSY:
  - Counter decrements each cycle.
  - When the counter reaches 1, the next state is ACK, so WaitRequest is low in cycle n+LATENCY.
- Entering ACK on a read: ReadData is registered from mem[index] on the transition edge and is valid throughout ACK.
- ACK on a write: the array is updated at the edge leaving ACK, only bytes with ByteEnable[i]=1. A read of the same word in the next transaction returns the new data.
- ACK always returns to IDLE. A new request is accepted at the earliest one cycle after ACK; back-to-back requests are never chained from ACK.
- Read and Write both high in IDLE: the read wins and the write is discarded (same priority as the master side).
- Request deasserted while BUSY (protocol violation): abort to IDLE, no array update, no ack cycle.
- Outside ACK, ReadData holds its last value.
- Reset mid-operation: immediately return to IDLE. A pending write is discarded; words already written are retained.
- Throughput: one access per LATENCY+1 cycles.

Optional Feature:
- Macro: DRAM_SLAVE_LFSR_JITTER_EN.
- Defined:
  - Adds a 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, reset seed 16'hACE1.
  - The LFSR advances once per accepted request.
  - Effective latency = LATENCY + lfsr[1:0] (0..3 extra BUSY cycles), sampled at acceptance.
- Undefined: no LFSR logic; latency is exactly LATENCY.

Decomposition:
- dram_slave_pkg:
  - state enum (IDLE, BUSY, ACK)
  - DATA_W=32, BE_W=4
  - LFSR_SEED and LFSR tap constants
  - function clog2_depth
- Sub-module dram_slave_mem: single-port word array with synchronous read, byte-enabled synchronous write, no reset.
- FSM, counter and LFSR stay in dram_slave.

Test Plan:
- Reset, then idle 5 cycles -> WaitRequest=1, ReadData=0 throughout.
- Write 32'hDEADBEEF to Address 32'h10 with BE=4'hF, LATENCY=4, request first high at cycle 0 -> WaitRequest low only in cycle 4. Then Read 32'h10 -> ReadData=32'hDEADBEEF in its ack cycle, also 4 cycles after request.
- Starting from 32'hDEADBEEF at 32'h10, write 32'h11223344 with BE=4'b0101 -> a following read returns 32'hDE22BE44.
- DEPTH=1024: write 32'hA5A5A5A5 to 32'h0000_1000, read 32'h0 -> 32'hA5A5A5A5 (wrap). Read 32'h13 -> same word as 32'h10.
- Read and Write both high at address 32'h20 -> a read is performed and the array is unchanged. Separately, drop Write during BUSY -> FSM back to IDLE, no ack, a later read shows old data.
- Assert reset in cycle 2 of a write's BUSY -> IDLE and WaitRequest=1 next cycle. A later read of that address returns the pre-write value. With DRAM_SLAVE_LFSR_JITTER_EN, the ack cycle for each of 8 consecutive reads matches a reference LFSR model.
